// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: state and cause encodings,
// per-cause flush masks and the default boot PC.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Numeric value is the priority; CAUSE_NONE marks the boot redirect.
  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_BJU    = 2'd1,
    CAUSE_FENCEI = 2'd2,
    CAUSE_TRAP   = 2'd3
  } cause_t;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  // bit0 = IF/ID flush, bit1 = ID/EX flush
  function automatic logic [1:0] flush_mask(input cause_t c);
    logic [1:0] m;
    case (c)
      CAUSE_BJU:    m = 2'b01;
      CAUSE_FENCEI: m = 2'b11;
      CAUSE_TRAP:   m = 2'b11;
      default:      m = 2'b00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_perf_cnt.sv
// Per-cause redirect counters and dropped-response counter; only instantiated
// when REDIRECT_PERF_EN is defined. All counters wrap at 2^XLEN.
module redirect_perf_cnt
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            latch_en,
  input  logic [1:0]      latch_cause,
  input  logic            drop_event,
  output logic [XLEN-1:0] perf_bju_cnt,
  output logic [XLEN-1:0] perf_trap_cnt,
  output logic [XLEN-1:0] perf_fencei_cnt,
  output logic [XLEN-1:0] perf_drop_cnt
);

  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  // Count accepted redirects by cause and cycles where a response was discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bju_cnt    <= '0;
      perf_trap_cnt   <= '0;
      perf_fencei_cnt <= '0;
      perf_drop_cnt   <= '0;
    end else begin
      if (latch_en) begin
        case (cause_t'(latch_cause))
          CAUSE_BJU:    perf_bju_cnt    <= perf_bju_cnt + ONE;
          CAUSE_FENCEI: perf_fencei_cnt <= perf_fencei_cnt + ONE;
          CAUSE_TRAP:   perf_trap_cnt   <= perf_trap_cnt + ONE;
          default:      perf_bju_cnt    <= perf_bju_cnt;
        endcase
      end
      if (drop_event) begin
        perf_drop_cnt <= perf_drop_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Front-end PC redirect sequencer: arbitrates trap > fence.i > branch, flushes the
// pipeline, drains stale fetches and offers the target to IF. Optional REDIRECT_PERF_EN.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bju_pc_b_j,
  input  logic [XLEN-1:0] bju_dnpc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            fencei_valid,
  input  logic [XLEN-1:0] fencei_pc,
  input  logic            fetch_inflight,
  input  logic            fetch_rsp_valid,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            drop_rsp,
  output logic            busy
`ifdef REDIRECT_PERF_EN
  ,
  output logic [XLEN-1:0] perf_bju_cnt,
  output logic [XLEN-1:0] perf_trap_cnt,
  output logic [XLEN-1:0] perf_fencei_cnt,
  output logic [XLEN-1:0] perf_drop_cnt
`endif
);

  state_t          state;
  cause_t          cause;
  cause_t          sel_cause;
  logic [XLEN-1:0] sel_target;
  logic            latch_en;
  logic [1:0]      sel_mask;

  // Pick the candidate cause; branches only count when nothing is in flight.
  always_comb begin
    sel_cause = CAUSE_NONE;
    if (trap_valid) begin
      sel_cause = CAUSE_TRAP;
    end else if (fencei_valid) begin
      sel_cause = CAUSE_FENCEI;
    end else if (bju_pc_b_j && (state == ST_IDLE)) begin
      sel_cause = CAUSE_BJU;
    end else begin
      sel_cause = CAUSE_NONE;
    end
  end

  // Decide whether the candidate is latched and which target it carries.
  always_comb begin
    latch_en = 1'b0;
    case (state)
      ST_IDLE:  latch_en = (sel_cause != CAUSE_NONE);
      ST_DRAIN: latch_en = (sel_cause > cause);
      ST_HOLD:  latch_en = (sel_cause > cause);
      default:  latch_en = 1'b0;
    endcase
    case (sel_cause)
      CAUSE_TRAP:   sel_target = trap_pc;
      CAUSE_FENCEI: sel_target = fencei_pc;
      CAUSE_BJU:    sel_target = bju_dnpc;
      default:      sel_target = '0;
    endcase
    sel_mask = flush_mask(sel_cause);
  end

  assign drop_rsp = (state == ST_DRAIN);

  // Redirect FSM with registered handshake, target, flush and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_BOOT;
      cause          <= CAUSE_NONE;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
      busy           <= 1'b1;
    end else begin
      flush_if_id <= latch_en & sel_mask[0];
      flush_id_ex <= latch_en & sel_mask[1];
      if (latch_en) begin
        redirect_pc <= sel_target;
        cause       <= sel_cause;
      end
      case (state)
        ST_BOOT: begin
          state          <= ST_HOLD;
          cause          <= CAUSE_NONE;
          redirect_pc    <= RESET_PC;
          redirect_valid <= 1'b1;
          busy           <= 1'b1;
        end
        ST_IDLE: begin
          if (latch_en) begin
            busy <= 1'b1;
            if (fetch_inflight && !fetch_rsp_valid) begin
              state          <= ST_DRAIN;
              redirect_valid <= 1'b0;
            end else begin
              state          <= ST_HOLD;
              redirect_valid <= 1'b1;
            end
          end else begin
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (fetch_rsp_valid) begin
            state          <= ST_HOLD;
            redirect_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          // A new winner accepted alongside the handshake must drain the fetch IF just issued.
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            if (latch_en) begin
              state <= ST_DRAIN;
              busy  <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state          <= ST_BOOT;
          redirect_valid <= 1'b0;
          busy           <= 1'b1;
        end
      endcase
    end
  end

`ifdef REDIRECT_PERF_EN
  redirect_perf_cnt #(.XLEN(XLEN)) u_perf (
    .clk             (clk),
    .rst             (rst),
    .latch_en        (latch_en),
    .latch_cause     (sel_cause),
    .drop_event      (drop_rsp & fetch_rsp_valid),
    .perf_bju_cnt    (perf_bju_cnt),
    .perf_trap_cnt   (perf_trap_cnt),
    .perf_fencei_cnt (perf_fencei_cnt),
    .perf_drop_cnt   (perf_drop_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios plus random traffic,
// checked against a pending-redirect reference model.
module tb_pc_redirect_ctrl;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst, bju_pc_b_j, trap_valid, fencei_valid;
  logic        fetch_inflight, fetch_rsp_valid, redirect_ready;
  logic [63:0] bju_dnpc, trap_pc, fencei_pc;
  logic        redirect_valid, flush_if_id, flush_id_ex, drop_rsp, busy;
  logic [63:0] redirect_pc;
`ifdef REDIRECT_PERF_EN
  logic [63:0] perf_bju_cnt, perf_trap_cnt, perf_fencei_cnt, perf_drop_cnt;
`endif

  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst),
    .bju_pc_b_j(bju_pc_b_j), .bju_dnpc(bju_dnpc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .fencei_valid(fencei_valid), .fencei_pc(fencei_pc),
    .fetch_inflight(fetch_inflight), .fetch_rsp_valid(fetch_rsp_valid),
    .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .drop_rsp(drop_rsp), .busy(busy)
`ifdef REDIRECT_PERF_EN
    , .perf_bju_cnt(perf_bju_cnt), .perf_trap_cnt(perf_trap_cnt),
    .perf_fencei_cnt(perf_fencei_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        fif;
    logic        fex;
    logic        drop;
    logic        busy;
    logic [63:0] c_bju;
    logic [63:0] c_trap;
    logic [63:0] c_fencei;
    logic [63:0] c_drop;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: one pending redirect with a priority, maybe awaiting a stale response.
  bit          m_boot, m_pend, m_wait, m_fif, m_fex;
  int          m_prio;
  logic [63:0] m_tgt, m_cb, m_ct, m_cf, m_cd;

  // Stimulus for the current cycle.
  bit          s_rst, s_b, s_t, s_f, s_inf, s_rsp, s_rdy;
  logic [63:0] s_bpc, s_tpc, s_fpc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  // Monitor: compare whatever the model predicted for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.valid});
      chk("redirect_pc", redirect_pc, e.pc);
      chk("flush_if_id", {63'd0, flush_if_id}, {63'd0, e.fif});
      chk("flush_id_ex", {63'd0, flush_id_ex}, {63'd0, e.fex});
      chk("drop_rsp", {63'd0, drop_rsp}, {63'd0, e.drop});
      chk("busy", {63'd0, busy}, {63'd0, e.busy});
`ifdef REDIRECT_PERF_EN
      chk("perf_bju_cnt", perf_bju_cnt, e.c_bju);
      chk("perf_trap_cnt", perf_trap_cnt, e.c_trap);
      chk("perf_fencei_cnt", perf_fencei_cnt, e.c_fencei);
      chk("perf_drop_cnt", perf_drop_cnt, e.c_drop);
`endif
    end
  end

  task automatic model_reset();
    m_boot = 1; m_pend = 0; m_wait = 0; m_fif = 0; m_fex = 0;
    m_prio = 0; m_tgt = RPC;
    m_cb = 64'd0; m_ct = 64'd0; m_cf = 64'd0; m_cd = 64'd0;
  endtask

  task automatic model_next();
    int np;
    bit take;
    m_fif = 0; m_fex = 0;
    if (s_rst) begin
      model_reset();
    end else begin
      if (m_wait && s_rsp) m_cd = m_cd + 64'd1;
      if (m_boot) begin
        m_boot = 0; m_pend = 1; m_wait = 0; m_tgt = RPC; m_prio = 0;
      end else begin
        np = s_t ? 3 : s_f ? 2 : (!m_pend && s_b) ? 1 : 0;
        take = np > (m_pend ? m_prio : 0);
        if (!m_pend) begin
          if (take) begin m_pend = 1; m_wait = s_inf && !s_rsp; end
        end else if (m_wait) begin
          if (s_rsp) m_wait = 0;
        end else if (s_rdy) begin
          if (take) m_wait = 1;
          else m_pend = 0;
        end
        if (take) begin
          m_tgt = (np == 3) ? s_tpc : (np == 2) ? s_fpc : s_bpc;
          m_prio = np;
          m_fif = 1;
          m_fex = (np >= 2);
          if (np == 3) m_ct = m_ct + 64'd1;
          else if (np == 2) m_cf = m_cf + 64'd1;
          else m_cb = m_cb + 64'd1;
        end
      end
    end
  endtask

  task automatic clear_stim();
    s_rst = 0; s_b = 0; s_t = 0; s_f = 0; s_inf = 0; s_rsp = 0; s_rdy = 0;
    s_bpc = 64'd0; s_tpc = 64'd0; s_fpc = 64'd0;
  endtask

  // One cycle: predict current outputs, drive this cycle's inputs, advance the model.
  task automatic step();
    exp_t e;
    e.valid = m_pend && !m_wait; e.pc = m_tgt;
    e.fif = m_fif; e.fex = m_fex; e.drop = m_wait;
    e.busy = m_boot || m_pend;
    e.c_bju = m_cb; e.c_trap = m_ct; e.c_fencei = m_cf; e.c_drop = m_cd;
    exp_q.push_back(e);
    rst = s_rst; bju_pc_b_j = s_b; bju_dnpc = s_bpc;
    trap_valid = s_t; trap_pc = s_tpc; fencei_valid = s_f; fencei_pc = s_fpc;
    fetch_inflight = s_inf; fetch_rsp_valid = s_rsp; redirect_ready = s_rdy;
    model_next();
    @(posedge clk);
    #1;
    clear_stim();
  endtask

  task automatic idle_steps(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin s_rdy = rdy; step(); end
  endtask

  initial begin
    clear_stim();
    rst = 1'b1; bju_pc_b_j = 1'b0; trap_valid = 1'b0; fencei_valid = 1'b0;
    fetch_inflight = 1'b0; fetch_rsp_valid = 1'b0; redirect_ready = 1'b0;
    bju_dnpc = 64'd0; trap_pc = 64'd0; fencei_pc = 64'd0;
    @(posedge clk); #1;
    model_reset();
    s_rst = 1; step();
    s_rst = 1; step();
    // Boot redirect.
    idle_steps(4, 1);
    // Branch with nothing in flight.
    s_b = 1; s_bpc = 64'h8000_0100; step();
    idle_steps(2, 0); idle_steps(2, 1);
    // Branch with a fetch in flight: drain.
    s_b = 1; s_bpc = 64'h8000_0300; s_inf = 1; step();
    idle_steps(2, 0);
    s_rsp = 1; step();
    idle_steps(1, 0); idle_steps(2, 1);
    // Trap overrides a draining branch; branch in HOLD ignored.
    s_b = 1; s_bpc = 64'h8000_0400; s_inf = 1; step();
    s_t = 1; s_tpc = 64'h8000_0200; step();
    idle_steps(1, 0);
    s_rsp = 1; step();
    s_b = 1; s_bpc = 64'h8000_0500; step();
    idle_steps(2, 1);
    // Simultaneous requests in IDLE.
    s_t = 1; s_tpc = 64'h8000_0600; s_f = 1; s_fpc = 64'h8000_0700;
    s_b = 1; s_bpc = 64'h8000_0800; step();
    idle_steps(1, 0); idle_steps(2, 1);
    // Handshake and higher-priority request in the same HOLD cycle.
    s_b = 1; s_bpc = 64'h8000_0900; step();
    s_f = 1; s_fpc = 64'h8000_0A00; s_rdy = 1; step();
    s_rsp = 1; step();
    idle_steps(2, 1);
    // Equal priority in HOLD ignored.
    s_f = 1; s_fpc = 64'h8000_0B00; step();
    s_f = 1; s_fpc = 64'h8000_0C00; step();
    idle_steps(2, 1);
    // Reset mid-HOLD, then boot again.
    s_t = 1; s_tpc = 64'h8000_0D00; step();
    idle_steps(1, 0);
    s_rst = 1; step();
    idle_steps(4, 1);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom_range(199) == 0);
      s_b   = ($urandom_range(2) == 0);
      s_t   = ($urandom_range(9) == 0);
      s_f   = ($urandom_range(9) == 0);
      s_inf = $urandom_range(1) == 1;
      s_rsp = ($urandom_range(2) == 0);
      s_rdy = $urandom_range(1) == 1;
      s_bpc = {$urandom, $urandom};
      s_tpc = {$urandom, $urandom};
      s_fpc = {$urandom, $urandom};
      if (m_boot || (m_pend && m_prio == 0)) begin s_t = 0; s_f = 0; end
      step();
    end
    step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
